// File: rtl/axis_mac_accumulator_pkg.sv
// Shared defaults and helpers for the MAC accumulator stage and its add sub-block.
package axis_mac_accumulator_pkg;

    localparam int DEF_DATA_WIDTH           = 16;
    localparam int DEF_WGHT_WIDTH           = 16;
    localparam int DEF_DATA_FRACTIONAL_BITS = 8;
    localparam int DEF_WGHT_FRACTIONAL_BITS = 8;
    localparam int DEF_ACC_WIDTH            = 40;
    localparam int DEF_ID_WIDTH             = 8;
    localparam int DEF_USER_WIDTH           = 1;

    // Largest of two widths; handy when sizing intermediate results.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axis_mac_accumulator_sat_add.sv
// Combinational saturating signed add with overflow flag.
module axis_mac_accumulator_sat_add #(
    parameter int WIDTH = 40
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] sum_o,
    output logic                    ovf_o
);

    localparam logic signed [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0] full_d;

    // One extra bit holds the exact sum; the top two bits disagree on overflow.
    always_comb begin
        full_d = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
        ovf_o  = full_d[WIDTH] ^ full_d[WIDTH-1];
        if (ovf_o) begin
            sum_o = full_d[WIDTH] ? SAT_NEG : SAT_POS;
        end else begin
            sum_o = full_d[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/axis_mac_accumulator.sv
// Two-stage multiply-accumulate over tlast-delimited AXI-Stream frames.
// Stage P registers the product; stage A accumulates with saturation and
// emits one wide sum per frame.
module axis_mac_accumulator
    import axis_mac_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
    parameter int WGHT_WIDTH           = DEF_WGHT_WIDTH,
    parameter int DATA_FRACTIONAL_BITS = DEF_DATA_FRACTIONAL_BITS,
    parameter int WGHT_FRACTIONAL_BITS = DEF_WGHT_FRACTIONAL_BITS,
    parameter int ACC_WIDTH            = DEF_ACC_WIDTH,
    parameter int ACC_FRACTIONAL_BITS  = DATA_FRACTIONAL_BITS + WGHT_FRACTIONAL_BITS,
    parameter bit ID_ENABLE            = 1'b0,
    parameter int ID_WIDTH             = DEF_ID_WIDTH,
    parameter bit USER_ENABLE          = 1'b1,
    parameter int USER_WIDTH           = DEF_USER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [WGHT_WIDTH-1:0] s_axis_twght,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [ACC_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_axis_tovf
);

    localparam int PW = DATA_WIDTH + WGHT_WIDTH;

    if (ACC_WIDTH < max_int(PW, 2)) begin : g_bad_acc_width
        $error("ACC_WIDTH (%0d) must be >= DATA_WIDTH+WGHT_WIDTH (%0d)", ACC_WIDTH, PW);
    end
    if (ACC_FRACTIONAL_BITS != DATA_FRACTIONAL_BITS + WGHT_FRACTIONAL_BITS) begin : g_bad_frac
        $error("ACC_FRACTIONAL_BITS is fixed to DATA_FRACTIONAL_BITS+WGHT_FRACTIONAL_BITS");
    end

    logic                         en;
    logic signed [DATA_WIDTH-1:0] data_s;
    logic signed [WGHT_WIDTH-1:0] wght_s;
    logic signed [PW-1:0]         prod_d;

    logic                         p_valid_q;
    logic signed [PW-1:0]         p_prod_q;
    logic                         p_last_q;
    logic [ID_WIDTH-1:0]          p_id_q;
    logic [USER_WIDTH-1:0]        p_user_q;

    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic                         ovf_acc_q;
    logic                         first_q;

    logic signed [ACC_WIDTH-1:0]  acc_base_d;
    logic signed [ACC_WIDTH-1:0]  prod_ext_d;
    logic signed [ACC_WIDTH-1:0]  sum_d;
    logic                         ovf_next_d;
    logic                         ovf_frame_d;

    logic [ACC_WIDTH-1:0]         m_data_q;
    logic                         m_valid_q;
    logic                         m_ovf_q;
    logic [ID_WIDTH-1:0]          m_id_q;
    logic [USER_WIDTH-1:0]        m_user_q;

    assign en            = !m_valid_q || m_axis_tready;
    assign s_axis_tready = en;

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = 1'b1;
    assign m_axis_tid    = m_id_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tovf   = m_ovf_q;

    // Full-width signed product and the operands for the frame accumulator.
    always_comb begin
        data_s      = s_axis_tdata;
        wght_s      = s_axis_twght;
        prod_d      = PW'(data_s) * PW'(wght_s);
        acc_base_d  = first_q ? '0 : acc_q;
        prod_ext_d  = ACC_WIDTH'(p_prod_q);
        ovf_frame_d = (first_q ? 1'b0 : ovf_acc_q) | ovf_next_d;
    end

    axis_mac_accumulator_sat_add #(
        .WIDTH(ACC_WIDTH)
    ) u_sat_add (
        .a_i  (acc_base_d),
        .b_i  (prod_ext_d),
        .sum_o(sum_d),
        .ovf_o(ovf_next_d)
    );

    // Product stage, accumulator and output register advance together on en.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q <= 1'b0;
            p_prod_q  <= '0;
            p_last_q  <= 1'b0;
            p_id_q    <= '0;
            p_user_q  <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            first_q   <= 1'b1;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_ovf_q   <= 1'b0;
            m_id_q    <= '0;
            m_user_q  <= '0;
        end else if (en) begin
            p_valid_q <= s_axis_tvalid;
            p_prod_q  <= prod_d;
            p_last_q  <= s_axis_tlast;
            p_id_q    <= ID_ENABLE ? s_axis_tid : '0;
            p_user_q  <= USER_ENABLE ? s_axis_tuser : '0;
            if (p_valid_q) begin
                if (p_last_q) begin
                    m_data_q  <= sum_d;
                    m_ovf_q   <= ovf_frame_d;
                    m_id_q    <= p_id_q;
                    m_user_q  <= p_user_q;
                    m_valid_q <= 1'b1;
                    first_q   <= 1'b1;
                end else begin
                    acc_q     <= sum_d;
                    ovf_acc_q <= ovf_frame_d;
                    first_q   <= 1'b0;
                    m_valid_q <= 1'b0;
                end
            end else begin
                m_valid_q <= 1'b0;
            end
        end
    end

endmodule
